// File: rtl/dcache_bank_scheduler_if.sv
// Request/issue bundle between the tile front end and the banked dcache data array.
// The master side presents tile requests; the slave side is the scheduler.
interface dcache_bank_scheduler_if #(
  parameter int SZ     = 4,
  parameter int LOGCNT = 5,
  parameter int BITS   = 18
);
  localparam int NE  = SZ * SZ;
  localparam int EW  = $clog2(NE);
  localparam int CNT = 1 << LOGCNT;
  localparam int AW  = 10 + LOGCNT;

  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_addr;
  logic [AW-2:0]        req_stride_x;
  logic [AW-2:0]        req_stride_y;
  logic                 req_we;
  logic [BITS*NE-1:0]   req_dat_w;

  logic                 issue_valid;
  logic                 issue_last;
  logic [NE-1:0]        issue_mask;
  logic [CNT-1:0]       bank_en;
  logic [10*CNT-1:0]    bank_row;
  logic [EW*CNT-1:0]    bank_elem;
  logic                 bank_we;
  logic [BITS*CNT-1:0]  bank_dat_w;

  modport master (
    output req_valid, req_addr, req_stride_x, req_stride_y, req_we, req_dat_w,
    input  req_ready, issue_valid, issue_last, issue_mask, bank_en, bank_row,
           bank_elem, bank_we, bank_dat_w
  );

  modport slave (
    input  req_valid, req_addr, req_stride_x, req_stride_y, req_we, req_dat_w,
    output req_ready, issue_valid, issue_last, issue_mask, bank_en, bank_row,
           bank_elem, bank_we, bank_dat_w
  );
endinterface

// File: rtl/dcache_bank_scheduler.sv
// Expands a strided SZ x SZ tile into per-element bank/row pairs and issues them to the
// banked data array, one element per bank per cycle, lowest element index first.
module dcache_bank_scheduler #(
  parameter int SZ     = 4,
  parameter int LOGCNT = 5,
  parameter int BITS   = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    freeze_i,
  dcache_bank_scheduler_if.slave  bus
);
  localparam int NE  = SZ * SZ;
  localparam int EW  = $clog2(NE);
  localparam int CNT = 1 << LOGCNT;
  localparam int AW  = 10 + LOGCNT;
  localparam int RW  = 10;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e              state_q, state_d;
  logic [NE-1:0]       pending_q, pending_d;
  logic                we_q, we_d;
  logic [LOGCNT-1:0]   bank_q [NE];
  logic [LOGCNT-1:0]   bank_d [NE];
  logic [RW-1:0]       row_q  [NE];
  logic [RW-1:0]       row_d  [NE];
  logic [BITS-1:0]     dat_q  [NE];
  logic [BITS-1:0]     dat_d  [NE];

  logic                issue_valid_q, issue_valid_d;
  logic                issue_last_q,  issue_last_d;
  logic [NE-1:0]       issue_mask_q,  issue_mask_d;
  logic [CNT-1:0]      bank_en_q,     bank_en_d;
  logic [RW*CNT-1:0]   bank_row_q,    bank_row_d;
  logic [EW*CNT-1:0]   bank_elem_q,   bank_elem_d;
  logic                bank_we_q,     bank_we_d;
  logic [BITS*CNT-1:0] bank_dat_q,    bank_dat_d;

  logic [AW-1:0]       addr_e [NE];
  logic [NE-1:0]       sel_mask;
  logic [CNT-1:0]      sel_en;
  logic [RW*CNT-1:0]   sel_row;
  logic [EW*CNT-1:0]   sel_elem;
  logic [BITS*CNT-1:0] sel_dat;
  logic                last_group;
  logic                ready;
  logic                accept;

  // Element addresses wrap modulo 2^AW; strides are zero-extended.
  always_comb begin
    for (int e = 0; e < NE; e++) begin
      addr_e[e] = bus.req_addr
                + AW'(e % SZ) * {1'b0, bus.req_stride_x}
                + AW'(e / SZ) * {1'b0, bus.req_stride_y};
    end
  end

  // An element is selected unless a lower-index pending element targets the same bank.
  always_comb begin
    sel_mask = '0;
    for (int e = 0; e < NE; e++) begin
      sel_mask[e] = pending_q[e];
      for (int f = 0; f < e; f++) begin
        if (pending_q[f] && (bank_q[f] == bank_q[e])) sel_mask[e] = 1'b0;
      end
    end
  end

  // At most one selected element per bank, so the routes never collide.
  always_comb begin
    sel_en   = '0;
    sel_row  = '0;
    sel_elem = '0;
    sel_dat  = '0;
    for (int e = 0; e < NE; e++) begin
      if (sel_mask[e]) begin
        sel_en[bank_q[e]]                       = 1'b1;
        sel_row[int'(bank_q[e])*RW +: RW]       = row_q[e];
        sel_elem[int'(bank_q[e])*EW +: EW]      = EW'(e);
        sel_dat[int'(bank_q[e])*BITS +: BITS]   = dat_q[e];
      end
    end
  end

  assign last_group = ~|(pending_q & ~sel_mask);
  assign ready      = !freeze_i && ((state_q == S_IDLE) || last_group);
  assign accept     = bus.req_valid && ready;

  // NOTE: every next-state variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    we_d          = we_q;
    bank_d        = bank_q;
    row_d         = row_q;
    dat_d         = dat_q;
    issue_valid_d = issue_valid_q;
    issue_last_d  = issue_last_q;
    issue_mask_d  = issue_mask_q;
    bank_en_d     = bank_en_q;
    bank_row_d    = bank_row_q;
    bank_elem_d   = bank_elem_q;
    bank_we_d     = bank_we_q;
    bank_dat_d    = bank_dat_q;

    if (!freeze_i) begin
      if (state_q == S_ISSUE) begin
        issue_valid_d = 1'b1;
        issue_last_d  = last_group;
        issue_mask_d  = sel_mask;
        bank_en_d     = sel_en;
        bank_row_d    = sel_row;
        bank_elem_d   = sel_elem;
        bank_we_d     = we_q;
        bank_dat_d    = sel_dat;
        pending_d     = pending_q & ~sel_mask;
        if (last_group) state_d = S_IDLE;
      end else begin
        issue_valid_d = 1'b0;
        issue_last_d  = 1'b0;
        issue_mask_d  = '0;
        bank_en_d     = '0;
        bank_row_d    = '0;
        bank_elem_d   = '0;
        bank_we_d     = 1'b0;
        bank_dat_d    = '0;
      end

      // A request accepted during the final group overrides the return to idle.
      if (accept) begin
        state_d   = S_ISSUE;
        pending_d = '1;
        we_d      = bus.req_we;
        for (int e = 0; e < NE; e++) begin
          bank_d[e] = addr_e[e][LOGCNT-1:0];
          row_d[e]  = addr_e[e][AW-1:LOGCNT];
          dat_d[e]  = bus.req_dat_w[BITS*e +: BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_last_q  <= 1'b0;
      issue_mask_q  <= '0;
      bank_en_q     <= '0;
      bank_row_q    <= '0;
      bank_elem_q   <= '0;
      bank_we_q     <= 1'b0;
      bank_dat_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      issue_valid_q <= issue_valid_d;
      issue_last_q  <= issue_last_d;
      issue_mask_q  <= issue_mask_d;
      bank_en_q     <= bank_en_d;
      bank_row_q    <= bank_row_d;
      bank_elem_q   <= bank_elem_d;
      bank_we_q     <= bank_we_d;
      bank_dat_q    <= bank_dat_d;
    end
  end

  // NOTE: the captured tile needs no reset; pending_q=0 keeps it from ever being used stale.
  always_ff @(posedge clk) begin
    we_q   <= we_d;
    bank_q <= bank_d;
    row_q  <= row_d;
    dat_q  <= dat_d;
  end

  assign bus.req_ready   = ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_last  = issue_last_q;
  assign bus.issue_mask  = issue_mask_q;
  assign bus.bank_en     = bank_en_q;
  assign bus.bank_row    = bank_row_q;
  assign bus.bank_elem   = bank_elem_q;
  assign bus.bank_we     = bank_we_q;
  assign bus.bank_dat_w  = bank_dat_q;
endmodule

// File: tb/tb_dcache_bank_scheduler.sv
// Scoreboard bench for dcache_bank_scheduler: each accepted tile is expanded by a
// bank-list model into expected issue groups, which a monitor compares cycle by cycle.
module tb_dcache_bank_scheduler;
  localparam int SZ     = 4;
  localparam int LOGCNT = 5;
  localparam int BITS   = 18;
  localparam int NE     = SZ * SZ;
  localparam int EW     = $clog2(NE);
  localparam int CNT    = 1 << LOGCNT;
  localparam int AW     = 10 + LOGCNT;

  typedef struct {
    int                  ta;
    logic [NE-1:0]       mask;
    logic [CNT-1:0]      en;
    logic [10*CNT-1:0]   row;
    logic [EW*CNT-1:0]   elem;
    logic [BITS*CNT-1:0] dat;
    logic                we;
    logic                last;
  } grp_t;

  logic clk = 1'b0;
  logic reset;
  logic freeze;
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  bit   rnd_done = 0;
  grp_t sb[$];

  dcache_bank_scheduler_if #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS)) bus ();

  dcache_bank_scheduler #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .freeze_i (freeze),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-bank element lists in ascending order; the k-th entry of every list forms group k.
  task automatic push_model(input int ta, input logic [AW-1:0] a, input logic [AW-2:0] sx,
                            input logic [AW-2:0] sy, input logic we, input logic [BITS*NE-1:0] d);
    int   adr [NE];
    int   lst [CNT][NE];
    int   cnt [CNT];
    int   n;
    grp_t g;
    n = 0;
    for (int b = 0; b < CNT; b++) cnt[b] = 0;
    for (int e = 0; e < NE; e++) begin
      adr[e] = (int'(a) + (e % SZ) * int'(sx) + (e / SZ) * int'(sy)) % (1 << AW);
      lst[adr[e] % CNT][cnt[adr[e] % CNT]] = e;
      cnt[adr[e] % CNT]++;
    end
    for (int b = 0; b < CNT; b++) if (cnt[b] > n) n = cnt[b];
    for (int k = 0; k < n; k++) begin
      g.ta = ta; g.mask = '0; g.en = '0; g.row = '0; g.elem = '0; g.dat = '0;
      g.we = we; g.last = (k == n - 1);
      for (int b = 0; b < CNT; b++) begin
        if (cnt[b] > k) begin
          int e;
          e = lst[b][k];
          g.mask[e]              = 1'b1;
          g.en[b]                = 1'b1;
          g.row[10*b +: 10]      = 10'(adr[e] / CNT);
          g.elem[EW*b +: EW]     = EW'(e);
          g.dat[BITS*b +: BITS]  = d[BITS*e +: BITS];
        end
      end
      sb.push_back(g);
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW-2:0] sx, input logic [AW-2:0] sy,
                      input logic we, input logic [BITS*NE-1:0] d);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_stride_x = sx; bus.req_stride_y = sy;
    bus.req_we = we; bus.req_dat_w = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.req_ready && !freeze && !reset;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (acc) push_model(edge_n, a, sx, sy, we, d);
    check("accept", {575'd0, acc}, 576'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.issue_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 576'(sb.size()), 576'd0);
  endtask

  // Monitor: one comparison set per cycle, chosen by what happened at the preceding edge.
  initial begin
    grp_t g;
    logic f, r;
    logic                p_valid, p_last, p_we;
    logic [NE-1:0]       p_mask;
    logic [CNT-1:0]      p_en;
    logic [10*CNT-1:0]   p_row;
    logic [EW*CNT-1:0]   p_elem;
    logic [BITS*CNT-1:0] p_dat;
    forever begin
      @(posedge clk);
      f = freeze; r = reset; edge_n++;
      @(negedge clk);
      if (r) begin
        sb.delete();
        check("rst_valid", 576'(bus.issue_valid), 576'd0);
        check("rst_last",  576'(bus.issue_last),  576'd0);
        check("rst_en",    576'(bus.bank_en),     576'd0);
        check("rst_mask",  576'(bus.issue_mask),  576'd0);
        check("rst_we",    576'(bus.bank_we),     576'd0);
        check("rst_dat",   576'(bus.bank_dat_w),  576'd0);
      end else if (f) begin
        check("hold_valid", 576'(bus.issue_valid), 576'(p_valid));
        check("hold_last",  576'(bus.issue_last),  576'(p_last));
        check("hold_mask",  576'(bus.issue_mask),  576'(p_mask));
        check("hold_en",    576'(bus.bank_en),     576'(p_en));
        check("hold_row",   576'(bus.bank_row),    576'(p_row));
        check("hold_elem",  576'(bus.bank_elem),   576'(p_elem));
        check("hold_we",    576'(bus.bank_we),     576'(p_we));
        check("hold_dat",   576'(bus.bank_dat_w),  576'(p_dat));
      end else if (sb.size() > 0 && sb[0].ta < edge_n) begin
        g = sb.pop_front();
        check("issue_valid", 576'(bus.issue_valid), 576'd1);
        check("issue_last",  576'(bus.issue_last),  576'(g.last));
        check("issue_mask",  576'(bus.issue_mask),  576'(g.mask));
        check("bank_en",     576'(bus.bank_en),     576'(g.en));
        check("bank_row",    576'(bus.bank_row),    576'(g.row));
        check("bank_elem",   576'(bus.bank_elem),   576'(g.elem));
        check("bank_we",     576'(bus.bank_we),     576'(g.we));
        check("bank_dat_w",  576'(bus.bank_dat_w),  576'(g.dat));
      end else begin
        check("idle_valid", 576'(bus.issue_valid), 576'd0);
        check("idle_en",    576'(bus.bank_en),     576'd0);
        check("idle_mask",  576'(bus.issue_mask),  576'd0);
        check("idle_we",    576'(bus.bank_we),     576'd0);
      end
      // Ready when at most the group being selected right now remains.
      check("req_ready", 576'(bus.req_ready), 576'(!freeze && sb.size() <= 1));
      p_valid = bus.issue_valid; p_last = bus.issue_last; p_we = bus.bank_we;
      p_mask = bus.issue_mask; p_en = bus.bank_en; p_row = bus.bank_row;
      p_elem = bus.bank_elem; p_dat = bus.bank_dat_w;
    end
  end

  initial begin
    logic [BITS*NE-1:0] d;
    reset = 1'b1; freeze = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_stride_x = '0; bus.req_stride_y = '0;
    bus.req_we = 1'b0; bus.req_dat_w = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Conflict-free tile, fully serialized tile, address wrap.
    send(15'd0, 14'd1, 14'd4, 1'b0, '0);          wait_idle();
    send(15'd0, 14'd32, 14'd128, 1'b0, '0);       wait_idle();
    send(15'h7FFF, 14'd1, 14'd4, 1'b0, '0);       wait_idle();

    // Sixteen writes to one address; data of element e is e.
    for (int e = 0; e < NE; e++) d[BITS*e +: BITS] = BITS'(e);
    send(15'd3, 14'd0, 14'd0, 1'b1, d);           wait_idle();

    // Eight-group tile A followed back-to-back by B, with a 3-cycle freeze inside A.
    fork
      begin
        send(15'd0, 14'd32, 14'd16, 1'b0, '0);
        send(15'd5, 14'd1, 14'd4, 1'b1, {NE{18'h2A5A5}});
      end
      begin
        repeat (4) @(posedge clk);
        #1 freeze = 1'b1;
        repeat (3) @(posedge clk);
        #1 freeze = 1'b0;
      end
    join
    wait_idle();

    // Reset during the third issue cycle of a serialized tile, then a fresh request.
    send(15'd0, 14'd32, 14'd128, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send(15'd64, 14'd1, 14'd4, 1'b0, '0);         wait_idle();

    // Random tiles with random freeze and random gaps.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [AW-2:0] sx, sy;
          for (int e = 0; e < NE; e++) d[BITS*e +: BITS] = BITS'($urandom);
          case ($urandom % 4)
            0: sx = 14'($urandom);
            1: sx = 14'(32 * ($urandom % 8));
            2: sx = 14'd1;
            default: sx = 14'd0;
          endcase
          case ($urandom % 4)
            0: sy = 14'($urandom);
            1: sy = 14'(32 * ($urandom % 8));
            2: sy = 14'd4;
            default: sy = 14'd0;
          endcase
          send(15'($urandom), sx, sy, 1'($urandom), d);
          repeat ($urandom % 3) @(posedge clk);
          #1;
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          freeze = ($urandom % 5 == 0);
        end
        freeze = 1'b0;
      end
    join
    wait_idle();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
